kv_pin_initiator: RTL
=====================

// Module: kv_pin_initiator
// PURPOSE
//  Initiator (master) end of the 8-bit strobe/ack key-value pin bus served by the pin-level keyvalue responder.
//  Accepts put/get commands on a valid/ready port and runs a 4-phase STB/ACK handshake on the pins.
//  Returns read data or a timeout error on a valid/ready response port.
//  Sits in a user project driving another chip's keyvalue responder through the IO pads.
// PARAMETERS
//  SYNC_STAGES  2     flops in the kv_ack_i synchronizer (>=2)
//  TIMEOUT      255   max sys_clk cycles to wait in each handshake phase (>=4)
// PORTS
//  sys_clk      in   1  single clock; all logic on rising edge
//  sys_rst_n    in   1  synchronous, active-low reset
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  command accepted when cmd_valid&&cmd_ready
//  cmd_we       in   1  1=put (write), 0=get (read)
//  cmd_key      in   8  key (pin address)
//  cmd_wdata    in   8  value for put
//  rsp_valid    out  1  response present; held until rsp_ready
//  rsp_ready    in   1  response consumed when rsp_valid&&rsp_ready
//  rsp_rdata    out  8  get data (0 for put or error)
//  rsp_err      out  1  1 = handshake timed out
//  kv_stb_o     out  1  request strobe to responder
//  kv_we_o      out  1  write enable to responder
//  kv_adr_o     out  8  key to responder
//  kv_dat_o     out  8  write value to responder
//  kv_dat_i     in   8  read value from responder (async)
//  kv_ack_i     in   1  acknowledge from responder (async)
// BEHAVIOUR
//  Reset (sys_rst_n=0 at edge): all outputs 0, state IDLE, sync chain cleared, timer 0; aborts any transaction (STB drops next edge).
//  ack_s = kv_ack_i after SYNC_STAGES flops; only ack_s is used by the FSM.
//  FSM states: IDLE, REQ, REL, RESP.
//  IDLE: cmd_ready = !ack_s (never start while responder still acks). On accept: latch we/key/wdata to kv_* outputs,
//   kv_stb_o=1 from next cycle, timer=0, go REQ. cmd_ready is 0 in every other state.
//  REQ: wait ack_s=1. On ack_s=1: capture kv_dat_i into rsp_rdata if !we (else 0), kv_stb_o=0, timer=0, go REL.
//   If timer reaches TIMEOUT first: kv_stb_o=0, rsp_err=1, rsp_rdata=0, go RESP.
//  REL: wait ack_s=0 -> go RESP with rsp_err=0. Timeout in REL -> rsp_err=1, rsp_rdata=0, go RESP.
//  RESP: rsp_valid=1, rsp_* stable; on rsp_ready: rsp_valid=0, go IDLE. rsp_ready ignored when rsp_valid=0.
//  kv_adr_o/kv_dat_o/kv_we_o stable from STB rise until STB fall; may hold last values afterwards.
//  Timer saturates; counts sys_clk cycles in REQ/REL only; 8-bit-or-wider per TIMEOUT.
//  Latency (no timeout, ack pin rises k cycles after STB): STB high cycle 1 after accept; rsp_valid at
//   cycle ~1+k+SYNC_STAGES+1+(release time)+SYNC_STAGES+1; one outstanding transaction max.
//  Simultaneous: cmd_valid while ack_s=1 in IDLE -> not accepted; command held by producer.
//  ack glitch in REQ shorter than SYNC_STAGES may be missed; protocol requires ack held until STB low.
// TESTING
//  1 put key=0x12 val=0xA5, model acks 3 cycles after STB, drops 2 after STB low -> pins adr=0x12 dat=0xA5 we=1; rsp err=0 rdata=0x00.
//  2 get key=0x34, model drives 0x5C with ack -> rsp_valid, rdata=0x5C, err=0; STB low within SYNC_STAGES+1 of ack.
//  3 model never acks -> STB drops after TIMEOUT cycles, rsp err=1 rdata=0; next cmd accepted once ack_s=0.
//  4 model holds ack high forever after put -> REL timeout, rsp err=1; cmd_ready stays 0 while ack_s=1.
//  5 rsp_ready low for 10 cycles -> rsp_valid/rdata stable, cmd_ready=0 throughout; back-to-back cmds one at a time.
//  6 sys_rst_n=0 mid-REQ -> next edge STB=0, rsp_valid=0, cmd_ready=1 once ack_s=0 after reset release.

Source files
------------

// File: rtl/kv_pin_initiator.sv
// kv_pin_initiator
//   Initiator end of the 8-bit STB/ACK key-value pin bus. Commands arrive on a
//   valid/ready port. Each one runs a 4-phase handshake on the pins:
//   STB up, wait for ACK, STB down, wait for ACK to drop. The result goes out
//   on a valid/ready response port. A phase that takes longer than TIMEOUT
//   cycles ends the transaction with rsp_err=1.
//
// Ports
//   sys_clk, sys_rst_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/cmd_key/cmd_wdata    1=put, 0=get; key; put value
//   rsp_valid/rsp_ready         response handshake (held until consumed)
//   rsp_rdata/rsp_err           get data (0 for put or error), timeout flag
//   kv_stb_o/kv_we_o            strobe and write enable to responder
//   kv_adr_o/kv_dat_o           key and write value to responder
//   kv_dat_i/kv_ack_i           read value and acknowledge from responder (async)
module kv_pin_initiator #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_key,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       kv_stb_o,
  output logic       kv_we_o,
  output logic [7:0] kv_adr_o,
  output logic [7:0] kv_dat_o,
  input  logic [7:0] kv_dat_i,
  input  logic       kv_ack_i
);

  localparam int TW_MIN = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_MIN > 8) ? TW_MIN : 8;

  typedef enum logic [1:0] {IDLE, REQ, REL, RESP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   kv_stb_q, kv_stb_d;
  logic                   kv_we_q, kv_we_d;
  logic [7:0]             kv_adr_q, kv_adr_d;
  logic [7:0]             kv_dat_q, kv_dat_d;

  logic ack_s;
  logic ack_s_next;
  logic timer_done;

  assign ack_s      = sync_q[SYNC_STAGES-1];
  // Value ack_s takes after this edge. It lets cmd_ready be registered and
  // still line up exactly with the ack_s that the FSM sees next cycle.
  assign ack_s_next = sync_q[SYNC_STAGES-2];
  assign timer_done = (timer_q == TW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], kv_ack_i};
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    kv_stb_d    = kv_stb_q;
    kv_we_d     = kv_we_q;
    kv_adr_d    = kv_adr_q;
    kv_dat_d    = kv_dat_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          kv_we_d  = cmd_we;
          kv_adr_d = cmd_key;
          kv_dat_d = cmd_wdata;
          kv_stb_d = 1'b1;
          timer_d  = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          // The responder drives kv_dat_i together with ACK, so the data has
          // settled by the time ACK has crossed the synchronizer.
          rsp_rdata_d = kv_we_q ? 8'h00 : kv_dat_i;
          rsp_err_d   = 1'b0;
          kv_stb_d    = 1'b0;
          timer_d     = '0;
          state_d     = REL;
        end else if (timer_done) begin
          kv_stb_d    = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REL: begin
        if (!ack_s) begin
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_done) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Never start a transaction while the responder is still acknowledging.
    cmd_ready_d = (state_d == IDLE) && !ack_s_next;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      timer_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      kv_stb_q    <= 1'b0;
      kv_we_q     <= 1'b0;
      kv_adr_q    <= 8'h00;
      kv_dat_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      timer_q     <= timer_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      kv_stb_q    <= kv_stb_d;
      kv_we_q     <= kv_we_d;
      kv_adr_q    <= kv_adr_d;
      kv_dat_q    <= kv_dat_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign kv_stb_o  = kv_stb_q;
  assign kv_we_o   = kv_we_q;
  assign kv_adr_o  = kv_adr_q;
  assign kv_dat_o  = kv_dat_q;

endmodule
